halli_galli_round_ctrl: RTL

Round sequencer for the Halli Galli game: decides whose turn it is, accepts the flip from the active player, pulses the random-card generator, waits for the card pipeline to settle, then opens a timed bell window. It arbitrates bell presses from the two players, samples the match verdict, and keeps both scores. It ends the game on deck exhaustion or on reaching the target score. It sits between the decoded keypad events and the card/score/display datapath, which it drives through single-cycle strobes.

---
 rtl/halli_galli_round_ctrl_pkg.sv | 50 +++++
 rtl/halli_galli_round_ctrl_if.sv | 28 ++
 rtl/halli_galli_round_ctrl_bell_arbiter.sv | 30 +++
 rtl/halli_galli_round_ctrl.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/halli_galli_round_ctrl_pkg.sv
// Shared types and constants for the Halli Galli round sequencer.
// Holds the state encoding, winner codes, player indices and the score step helper.
package halli_galli_round_ctrl_pkg;

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_WAIT_FLIP = 3'd1;
   localparam logic [2:0] ST_DEAL      = 3'd2;
   localparam logic [2:0] ST_SETTLE    = 3'd3;
   localparam logic [2:0] ST_WINDOW    = 3'd4;
   localparam logic [2:0] ST_JUDGE     = 3'd5;
   localparam logic [2:0] ST_FINISH    = 3'd6;

   typedef enum logic [2:0] {
      StIdle     = ST_IDLE,
      StWaitFlip = ST_WAIT_FLIP,
      StDeal     = ST_DEAL,
      StSettle   = ST_SETTLE,
      StWindow   = ST_WINDOW,
      StJudge    = ST_JUDGE,
      StFinish   = ST_FINISH
   } state_e;

   localparam logic [1:0] WIN_NONE = 2'b00;
   localparam logic [1:0] WIN_A    = 2'b01;
   localparam logic [1:0] WIN_B    = 2'b10;
   localparam logic [1:0] WIN_TIE  = 2'b11;

   localparam logic PLAYER_A = 1'b0;
   localparam logic PLAYER_B = 1'b1;

   localparam logic [3:0] SCORE_MAX = 4'd15;

   // Saturating +1 on a correct bell, -1 on a wrong one.
   function automatic logic [3:0] score_step(input logic [3:0] s, input logic up);
      if (up) begin
         return (s == SCORE_MAX) ? s : s + 4'd1;
      end
      return (s == 4'd0) ? s : s - 4'd1;
   endfunction

   function automatic logic [1:0] winner_of(input logic [3:0] a, input logic [3:0] b);
      if (a > b) begin
         return WIN_A;
      end else if (b > a) begin
         return WIN_B;
      end
      return WIN_TIE;
   endfunction

endpackage

// File: rtl/halli_galli_round_ctrl_if.sv
// Keypad events and datapath strobes exchanged with the round sequencer.
// master = the sequencer, slave = keypad decoder plus card/score/display datapath.
interface halli_galli_round_ctrl_if;

   logic       flip_a;
   logic       flip_b;
   logic       bell_a;
   logic       bell_b;
   logic       match;
   logic       deal_en;
   logic       turn;
   logic       window_open;
   logic [3:0] score_a;
   logic [3:0] score_b;
   logic [1:0] winner;
   logic       finish;

   modport master (
      input  flip_a, flip_b, bell_a, bell_b, match,
      output deal_en, turn, window_open, score_a, score_b, winner, finish
   );

   modport slave (
      output flip_a, flip_b, bell_a, bell_b, match,
      input  deal_en, turn, window_open, score_a, score_b, winner, finish
   );

endinterface

// File: rtl/halli_galli_round_ctrl_bell_arbiter.sv
// Bell arbiter: picks the presser while enabled; simultaneous presses go to the
// player holding priority, which then passes to the other player.
module halli_galli_round_ctrl_bell_arbiter
   import halli_galli_round_ctrl_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic bell_a,
   input  logic bell_b,
   input  logic enable,
   output logic grant,
   output logic grant_who
);

   logic prio_q;
   logic tie;

   assign tie       = enable & bell_a & bell_b;
   assign grant     = enable & (bell_a | bell_b);
   assign grant_who = tie ? prio_q : (bell_b ? PLAYER_B : PLAYER_A);

   always_ff @(posedge clk) begin
      if (rst) begin
         prio_q <= PLAYER_A;
      end else if (tie) begin
         prio_q <= ~prio_q;
      end
   end

endmodule

// File: rtl/halli_galli_round_ctrl.sv
// Halli Galli round sequencer: turn gating, deal strobe, settle and bell windows,
// bell judging, score keeping and end-of-game detection.
module halli_galli_round_ctrl
   import halli_galli_round_ctrl_pkg::*;
#(
   parameter logic [7:0]  DECK_SIZE     = 8'd56,
   parameter logic [3:0]  WIN_SCORE     = 4'd7,
   parameter logic [3:0]  SETTLE_CYCLES = 4'd4,
   parameter logic [23:0] WINDOW_CYCLES = 24'd10_000_000
) (
   input logic                      clk,
   input logic                      rst,
   halli_galli_round_ctrl_if.master bus
);

   localparam logic [23:0] SETTLE_LAST = 24'(SETTLE_CYCLES) - 24'd1;
   localparam logic [23:0] WINDOW_LAST = WINDOW_CYCLES - 24'd1;

   state_e      state_q, state_d;
   logic [23:0] timer_q, timer_d;
   logic [7:0]  cards_q, cards_d;
   logic [3:0]  score_a_q, score_a_d;
   logic [3:0]  score_b_q, score_b_d;
   logic        turn_q, turn_d;
   logic        presser_q, presser_d;
   logic        deal_en_q, window_open_q, finish_q;
   logic [1:0]  winner_q;
   logic        end_check;
   logic        grant, grant_who;

   halli_galli_round_ctrl_bell_arbiter u_bell_arbiter (
      .clk       (clk),
      .rst       (rst),
      .bell_a    (bus.bell_a),
      .bell_b    (bus.bell_b),
      .enable    (state_q == StWindow),
      .grant     (grant),
      .grant_who (grant_who)
   );

   always_comb begin
      state_d   = state_q;
      timer_d   = timer_q;
      cards_d   = cards_q;
      score_a_d = score_a_q;
      score_b_d = score_b_q;
      turn_d    = turn_q;
      presser_d = presser_q;
      end_check = 1'b0;

      unique case (state_q)
         StIdle: state_d = StWaitFlip;
         StWaitFlip: begin
            if ((turn_q == PLAYER_A && bus.flip_a) || (turn_q == PLAYER_B && bus.flip_b)) begin
               state_d = StDeal;
            end
         end
         StDeal: begin
            cards_d = cards_q + 8'd1;
            timer_d = '0;
            state_d = StSettle;
         end
         StSettle: begin
            if (timer_q == SETTLE_LAST) begin
               timer_d = '0;
               state_d = StWindow;
            end else begin
               timer_d = timer_q + 24'd1;
            end
         end
         StWindow: begin
            // A press in the final window cycle wins over the timeout.
            if (grant) begin
               presser_d = grant_who;
               state_d   = StJudge;
            end else if (timer_q == WINDOW_LAST) begin
               turn_d    = ~turn_q;
               end_check = 1'b1;
            end else begin
               timer_d = timer_q + 24'd1;
            end
         end
         StJudge: begin
            if (presser_q == PLAYER_A) begin
               score_a_d = score_step(score_a_q, bus.match);
            end else begin
               score_b_d = score_step(score_b_q, bus.match);
            end
            turn_d    = ~turn_q;
            end_check = 1'b1;
         end
         StFinish: state_d = StFinish;
         default:  state_d = StIdle;
      endcase

      // End check sees the post-judge scores so a winning bell finishes immediately.
      if (end_check) begin
         if (score_a_d >= WIN_SCORE || score_b_d >= WIN_SCORE || cards_q == DECK_SIZE) begin
            state_d = StFinish;
         end else begin
            state_d = StWaitFlip;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= StIdle;
         timer_q       <= '0;
         cards_q       <= '0;
         score_a_q     <= '0;
         score_b_q     <= '0;
         turn_q        <= PLAYER_A;
         presser_q     <= PLAYER_A;
         deal_en_q     <= 1'b0;
         window_open_q <= 1'b0;
         finish_q      <= 1'b0;
         winner_q      <= WIN_NONE;
      end else begin
         state_q       <= state_d;
         timer_q       <= timer_d;
         cards_q       <= cards_d;
         score_a_q     <= score_a_d;
         score_b_q     <= score_b_d;
         turn_q        <= turn_d;
         presser_q     <= presser_d;
         deal_en_q     <= (state_d == StDeal);
         window_open_q <= (state_d == StWindow);
         finish_q      <= (state_d == StFinish);
         winner_q      <= (state_d == StFinish) ? winner_of(score_a_d, score_b_d) : WIN_NONE;
      end
   end

   assign bus.deal_en     = deal_en_q;
   assign bus.turn        = turn_q;
   assign bus.window_open = window_open_q;
   assign bus.score_a     = score_a_q;
   assign bus.score_b     = score_b_q;
   assign bus.winner      = winner_q;
   assign bus.finish      = finish_q;

endmodule
